topo2a_mul_share_sched: RTL and testbench

//  Round-robin scheduler that time-shares one signed 19x8 multiplier among NUM_REQ requesters in the

---
 rtl/topo2a_mul_share_sched.sv | 125 ++++++++++++
 tb/tb_topo2a_mul_share_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/topo2a_mul_share_sched.sv
// Round-robin scheduler time-sharing one signed A_W x B_W multiplier among NUM_REQ requesters.
// Define TOPO2A_MUL_SAT_EN to saturate results to P_W bits; otherwise the product wraps.
module topo2a_mul_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 19,
    parameter int B_W     = 8,
    parameter int P_W     = 23,
    parameter int ID_W    = 2
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*A_W-1:0]    req_a,
    input  logic [NUM_REQ*B_W-1:0]    req_b,
    output logic signed [A_W-1:0]     mul_din0,
    output logic signed [B_W-1:0]     mul_din1,
    input  logic signed [A_W+B_W-1:0] mul_dout,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic signed [P_W-1:0]     rsp_data,
    output logic [ID_W-1:0]           rsp_id
);
    localparam int M_W = A_W + B_W;

    logic                  iss_vld;
    logic signed [A_W-1:0] iss_a;
    logic signed [B_W-1:0] iss_b;
    logic [ID_W-1:0]       iss_id;
    logic [ID_W-1:0]       ptr;
    logic                  rsp_adv;
    logic                  iss_free;
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic [A_W-1:0]        sel_a;
    logic [B_W-1:0]        sel_b;

`ifdef TOPO2A_MUL_SAT_EN
    function automatic logic signed [P_W-1:0] narrow(input logic signed [M_W-1:0] prod);
        // In range when every bit above the result sign bit repeats the product sign.
        if (prod[M_W-1:P_W-1] == {(M_W-P_W+1){prod[M_W-1]}})
            return prod[P_W-1:0];
        else if (prod[M_W-1])
            return {1'b1, {(P_W-1){1'b0}}};
        else
            return {1'b0, {(P_W-1){1'b1}}};
    endfunction
`else
    function automatic logic signed [P_W-1:0] narrow(input logic signed [P_W-1:0] prod_lo);
        return prod_lo;
    endfunction

    logic unused_prod_hi;
    assign unused_prod_hi = ^mul_dout[M_W-1:P_W];
`endif

    assign rsp_adv  = iss_vld & (~rsp_valid | rsp_ready);
    assign iss_free = ~iss_vld | rsp_adv;
    assign mul_din0 = iss_a;
    assign mul_din1 = iss_b;

    // Search starts just after the last granted requester and wraps around.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && req_valid[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[i*A_W +: A_W];
                sel_b = req_b[i*B_W +: B_W];
            end
        end
    end

    // Held at zero while in reset so no handshake can complete before release.
    assign req_ready = (ap_rst_n && iss_free && grant_vld) ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            iss_vld   <= 1'b0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_id    <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (iss_free) begin
                iss_vld <= grant_vld;
                if (grant_vld) begin
                    iss_a  <= sel_a;
                    iss_b  <= sel_b;
                    iss_id <= grant_id;
                    ptr    <= grant_id;
                end
            end
            // Response stage: reload on advance, otherwise retire on accept.
            if (rsp_adv) begin
`ifdef TOPO2A_MUL_SAT_EN
                rsp_data <= narrow(mul_dout);
`else
                rsp_data <= narrow(mul_dout[P_W-1:0]);
`endif
                rsp_id    <= iss_id;
                rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_topo2a_mul_share_sched.sv
// Scoreboard bench for topo2a_mul_share_sched: directed requests push expected results, a monitor pops them.
`timescale 1ns/1ps
module tb_topo2a_mul_share_sched;
    localparam int NUM_REQ = 4;
    localparam int A_W     = 19;
    localparam int B_W     = 8;
    localparam int P_W     = 23;
    localparam int ID_W    = 2;

`ifdef TOPO2A_MUL_SAT_EN
    localparam int EXP_POS_BIG = 4194303;
    localparam int EXP_POW25   = 4194303;
    localparam int EXP_NEG_BIG = -4194304;
`else
    localparam int EXP_POS_BIG = -262271;
    localparam int EXP_POW25   = 0;
    localparam int EXP_NEG_BIG = 262144;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*A_W-1:0]    req_a;
    logic [NUM_REQ*B_W-1:0]    req_b;
    logic signed [A_W-1:0]     mul_din0;
    logic signed [B_W-1:0]     mul_din1;
    logic signed [A_W+B_W-1:0] mul_dout;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic signed [P_W-1:0]     rsp_data;
    logic [ID_W-1:0]           rsp_id;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;
    int   t2_exp[4] = '{-200, -200, 0, 400};

    always #5 clk = ~clk;

    // Zero-latency multiplier model; low A_W+B_W bits of the sign-extended product.
    assign mul_dout = {{B_W{mul_din0[A_W-1]}}, mul_din0} * {{A_W{mul_din1[B_W-1]}}, mul_din1};

    topo2a_mul_share_sched #(
        .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_proto
        assert property (@(posedge clk) disable iff (!rst_n)
                         (req_valid[g] && !req_ready[g]) |=> req_valid[g])
            else $error("req_valid[%0d] dropped before handshake", g);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int id, input int a, input int b);
        req_a[id*A_W +: A_W] = A_W'(a);
        req_b[id*B_W +: B_W] = B_W'(b);
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic issue1(input int id, input int a, input int b, input int exp);
        bit got;
        got = 1'b0;
        set_req(id, a, b);
        req_valid[id] = 1'b1;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                push(id, exp);
            end
            next_drive();
        end
        req_valid[id] = 1'b0;
        check($sformatf("issue1_grant_req%0d", id), int'(got), 1);
    endtask

    // Monitor: every accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp: got id %0d data %0d, required no response",
                         rsp_id, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", int'(rsp_id), mon_e.id);
                check("rsp_data", int'(rsp_data), mon_e.data);
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_valid = '1;

        // Reset state, with all requests raised so req_ready gating is visible.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_din0", int'(mul_din0), 0);
        check("reset_din1", int'(mul_din1), 0);
        req_valid = '0;
        next_drive();
        rst_n = 1'b1;
        next_drive();

        // Single request from requester 1, latency of two cycles.
        set_req(1, 1000, -3);
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("t1_grant", int'(req_ready), 4'b0010);
        push(1, -3000);
        next_drive();
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("t1_valid_n1", int'(rsp_valid), 0);
        check("t1_din0", int'(mul_din0), 1000);
        check("t1_din1", int'(mul_din1), -3);
        @(negedge clk);
        check("t1_valid_n2", int'(rsp_valid), 1);
        next_drive();
        repeat (2) next_drive();

        // Fresh reset, then all four requesting: round robin 0,1,2,3,0,1,2,3.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_drive();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 100 * (i + 1), i - 2);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_grant", int'(req_ready), 1 << (k % 4));
            check("t2_rsp_valid", int'(rsp_valid), int'(k >= 2));
            push(k % 4, t2_exp[k % 4]);
            next_drive();
            if (k >= 4) req_valid[k % 4] = 1'b0;
        end
        repeat (4) next_drive();

        // Backpressure: response held, one more issue accepted, then stall.
        rsp_ready = 1'b0;
        set_req(0, 7, 5);
        set_req(2, -9, 11);
        set_req(3, 12, -12);
        req_valid = 4'b1101;
        @(negedge clk);
        check("t3_grant0", int'(req_ready), 4'b0001);
        push(0, 35);
        next_drive();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t3_grant2", int'(req_ready), 4'b0100);
        push(2, -99);
        next_drive();
        req_valid[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_stall_ready", int'(req_ready), 0);
            check("t3_stall_valid", int'(rsp_valid), 1);
            check("t3_stall_data", int'(rsp_data), 35);
            check("t3_stall_id", int'(rsp_id), 0);
            next_drive();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_grant3", int'(req_ready), 4'b1000);
        push(3, -144);
        next_drive();
        req_valid[3] = 1'b0;
        repeat (4) next_drive();

        // Narrowing boundaries.
        issue1(1, 262143, 127, EXP_POS_BIG);
        issue1(1, -262144, -128, EXP_POW25);
        issue1(2, -262144, 127, EXP_NEG_BIG);
        repeat (4) next_drive();

        // Reset in the middle of a stalled stream.
        rsp_ready = 1'b0;
        issue1(0, 3, 4, 12);
        issue1(1, -5, 6, -30);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 100 * (i + 1), i - 2);
        req_valid = '1;
        @(negedge clk);
        check("t6_pre_valid", int'(rsp_valid), 1);
        check("t6_pre_ready", int'(req_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(rsp_valid), 0);
        check("t6_rst_ready", int'(req_ready), 0);
        check("t6_rst_din0", int'(mul_din0), 0);
        check("t6_rst_din1", int'(mul_din1), 0);
        exp_q.delete();
        rsp_ready = 1'b1;
        next_drive();
        rst_n = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            @(negedge clk);
            check("t6_grant", int'(req_ready), 1 << k);
            if (k == 0) check("t6_no_stale_rsp", int'(rsp_valid), 0);
            push(k, t2_exp[k]);
            next_drive();
            req_valid[k] = 1'b0;
        end

        // Drain: every expected result must have come out.
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) next_drive();
        check("drain_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
